number_display_driver: RTL and testbench



---
 rtl/display_pkg.sv | 59 +++++
 rtl/bin16_to_bcd_seq.sv | 88 ++++++++
 rtl/number_display_driver.sv | 110 +++++++++++
 tb/tb_number_display_driver.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared constants, types and helpers for the number display driver.
//   - Active-low seven-segment codes {g,f,e,d,c,b,a} for hex digits 0..F and the blank code.
//   - N_DIGITS: number of multiplexed digit slots on the display.
//   - conv_state_e: state of the sequential binary-to-BCD converter.
//   - seg_decode(): nibble to segment-code lookup.
package display_pkg;

    localparam int unsigned N_DIGITS = 8;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } conv_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_OFF;
        unique case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin16_to_bcd_seq.sv
// bin16_to_bcd_seq: sequential double-dabble converter, 16-bit binary to 5 BCD digits.
// Watches bin; whenever it differs from the last captured value and the converter is idle,
// captures it and runs 16 shift/adjust steps. bcd only updates on completion, so it always
// holds a complete result.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   bin   - binary value to convert
//   bcd   - last completed result, {ten-thousands, thousands, hundreds, tens, units}
//   busy  - high in LOAD, SHIFT and DONE
//   value - captured binary value (num_q), used by the hex display path
module bin16_to_bcd_seq
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bin,
    output logic [19:0] bcd,
    output logic        busy,
    output logic [15:0] value
);

    conv_state_e state_q;
    logic [15:0] num_q;
    logic [35:0] shift_q;
    logic [35:0] shift_adj;
    logic [3:0]  iter_q;
    logic [19:0] bcd_q;
    logic        busy_q;

    // Add 3 to every BCD nibble >= 5 before the shift so it carries correctly into the next digit.
    always_comb begin
        shift_adj = shift_q;
        for (int i = 0; i < 5; i++) begin
            if (shift_q[16 + 4 * i +: 4] >= 4'd5) begin
                shift_adj[16 + 4 * i +: 4] = shift_q[16 + 4 * i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            num_q   <= 16'd0;
            shift_q <= 36'd0;
            iter_q  <= 4'd0;
            bcd_q   <= 20'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bin != num_q) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    num_q   <= bin;
                    shift_q <= {20'd0, bin};
                    iter_q  <= 4'd0;
                    state_q <= SHIFT;
                    busy_q  <= 1'b1;
                end
                SHIFT: begin
                    shift_q <= {shift_adj[34:0], 1'b0};
                    iter_q  <= iter_q + 4'd1;
                    if (iter_q == 4'd15) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q   <= shift_q[35:16];
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd   = bcd_q;
    assign busy  = busy_q;
    assign value = num_q;

endmodule

// File: rtl/number_display_driver.sv
// number_display_driver: drives an 8-digit multiplexed active-low seven-segment display.
// Hex mode shows the captured number as 4 hex digits; decimal mode shows the 5-digit BCD
// result of the sequential converter. Optional leading-zero blanking in both modes.
// Ports:
//   clk         - system clock
//   rst         - synchronous active-high reset
//   number      - 16-bit value to display
//   dec_mode    - 1 = unsigned decimal, 0 = hex
//   blank_zeros - 1 = blank leading zeros (digit 0 always shown)
//   anodes      - active-low one-hot digit enables, bit 0 = rightmost digit
//   segments    - active-low {g,f,e,d,c,b,a}
//   busy        - BCD conversion in progress
module number_display_driver
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] number,
    input  logic        dec_mode,
    input  logic        blank_zeros,
    output logic [7:0]  anodes,
    output logic [6:0]  segments,
    output logic        busy
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [19:0]      bcd;
    logic [15:0]      num_q;

    logic [3:0]       digits [N_DIGITS];
    logic [7:0]       used;
    logic [7:0]       lit;
    logic             seen_nonzero;
    logic [7:0]       anodes_d;
    logic [6:0]       segments_d;

    bin16_to_bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .bin   (number),
        .bcd   (bcd),
        .busy  (busy),
        .value (num_q)
    );

    // Digit source mux.
    always_comb begin
        for (int k = 0; k < int'(N_DIGITS); k++) begin
            digits[k] = 4'h0;
        end
        if (dec_mode) begin
            for (int k = 0; k < 5; k++) begin
                digits[k] = bcd[4 * k +: 4];
            end
            used = 8'h1F;
        end else begin
            for (int k = 0; k < 4; k++) begin
                digits[k] = num_q[4 * k +: 4];
            end
            used = 8'h0F;
        end
    end

    // Walk from the most significant slot down; a digit is blanked only while every used digit
    // at or above it is zero.
    always_comb begin
        seen_nonzero = 1'b0;
        lit          = 8'h00;
        for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
            if (used[k] && (digits[k] != 4'h0)) begin
                seen_nonzero = 1'b1;
            end
            lit[k] = used[k] && ((k == 0) || !blank_zeros || seen_nonzero);
        end
    end

    always_comb begin
        anodes_d   = 8'hFF;
        segments_d = SEG_OFF;
        if (lit[idx_q]) begin
            anodes_d[idx_q] = 1'b0;
            segments_d      = seg_decode(digits[idx_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            anodes   <= 8'hFF;
            segments <= SEG_OFF;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                idx_q <= idx_q + 3'd1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            anodes   <= anodes_d;
            segments <= segments_d;
        end
    end

endmodule

// File: tb/tb_number_display_driver.sv
module tb_number_display_driver;

    localparam int unsigned RDIV = 4;

    logic        clk;
    logic        rst;
    logic [15:0] number;
    logic        dec_mode;
    logic        blank_zeros;
    logic [7:0]  anodes;
    logic [6:0]  segments;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [6:0] exp_seg [8];

    number_display_driver #(
        .REFRESH_DIV (RDIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .number      (number),
        .dec_mode    (dec_mode),
        .blank_zeros (blank_zeros),
        .anodes      (anodes),
        .segments    (segments),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, want);
        end
    endtask

    // Sample #1 after the active edge; cyc counts edges since reset release.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected segment codes {s7..s0}; 7F marks an off slot.
    task automatic set_exp(input logic [55:0] v);
        for (int k = 0; k < 8; k++) exp_seg[k] = v[7 * k +: 7];
    endtask

    // Output after edge n (n >= 1) belongs to slot ((n-1)/RDIV) mod 8.
    task automatic check_slot(input string tag);
        int   slot;
        logic [7:0] e_an;
        slot = ((cyc - 1) / int'(RDIV)) % 8;
        e_an = 8'hFF;
        if (exp_seg[slot] != 7'h7F) e_an[slot] = 1'b0;
        check({tag, "_an"}, {24'd0, anodes}, {24'd0, e_an});
        check({tag, "_seg"}, {25'd0, segments}, {25'd0, exp_seg[slot]});
    endtask

    task automatic window(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check_slot(tag);
            tick();
        end
    endtask

    initial begin
        rst         = 1'b1;
        number      = 16'd1234;
        dec_mode    = 1'b0;
        blank_zeros = 1'b1;

        // Reset held with a nonzero input: outputs stay off, no conversion.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_an", {24'd0, anodes}, 32'hFF);
            check("rst_seg", {25'd0, segments}, 32'h7F);
            check("rst_busy", {31'd0, busy}, 32'd0);
        end

        // Hex 00A5 with blanking.
        rst    = 1'b0;
        number = 16'h00A5;
        cyc    = 0;
        tick(); tick(); tick();
        set_exp({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12});
        window("hex_blank", 32);

        // Same value, blanking off.
        blank_zeros = 1'b0;
        tick();
        set_exp({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h08, 7'h12});
        window("hex_noblank", 32);

        // Decimal FFFF: busy for 18 cycles then 65535 displayed.
        dec_mode = 1'b1;
        number   = 16'hFFFF;
        for (int i = 0; i < 18; i++) begin
            tick();
            check("ffff_busy", {31'd0, busy}, 32'd1);
        end
        tick();
        check("ffff_idle", {31'd0, busy}, 32'd0);
        tick();
        set_exp({7'h7F, 7'h7F, 7'h7F, 7'h02, 7'h12, 7'h12, 7'h30, 7'h12});
        window("dec_65535", 32);

        // Mid-conversion change: 1234, then 9999 at busy cycle 5.
        blank_zeros = 1'b1;
        number      = 16'd1234;
        for (int i = 1; i <= 18; i++) begin
            tick();
            check("mid_busy", {31'd0, busy}, 32'd1);
            if (i == 5) number = 16'd9999;
        end
        tick();
        check("mid_gap", {31'd0, busy}, 32'd0);
        tick();
        check("mid_restart", {31'd0, busy}, 32'd1);
        set_exp({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});
        window("dec_01234", 19);
        set_exp({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h10, 7'h10, 7'h10});
        window("dec_09999", 32);

        // Scan wrap, hex 8888, blanking off.
        dec_mode    = 1'b0;
        blank_zeros = 1'b0;
        number      = 16'h8888;
        tick(); tick(); tick(); tick();
        set_exp({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00, 7'h00, 7'h00, 7'h00});
        window("scan", 33);

        // Reset during SHIFT.
        dec_mode    = 1'b1;
        blank_zeros = 1'b1;
        number      = 16'd500;
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        check("shift_rst_busy", {31'd0, busy}, 32'd0);
        check("shift_rst_an", {24'd0, anodes}, 32'hFF);
        rst    = 1'b0;
        number = 16'd42;
        cyc    = 0;
        tick();
        check("r42_busy", {31'd0, busy}, 32'd1);
        set_exp({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        window("dec_zero", 19);
        check("r42_idle", {31'd0, busy}, 32'd0);
        set_exp({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});
        window("dec_42", 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
